// File: rtl/mem_pkg.sv
// Shared definitions for the data-cache miss path.
// Provides the line geometry, the miss-controller FSM state type and
// helpers that turn a byte address into a line base or a word address.
package mem_pkg;

  localparam int ADDR_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 4;
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE);

  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    TAG
  } state_e;

  // Clears the byte-offset bits so the result points at word 0 of the line.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

  // Byte address of word idx within the line starting at base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]     base,
                                                  input logic [WORD_IDX_W-1:0] idx);
    return base + {{(ADDR_W-WORD_IDX_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/line_word_counter.sv
// Word index within a cache line, shared by eviction and refill.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   inc           advance to the next word (wraps after the last word)
//   clr           return to word 0 (wins over inc)
//   word_idx      current word index
//   is_last       current word is the final word of the line
module line_word_counter
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inc,
  input  logic                  clr,
  output logic [WORD_IDX_W-1:0] word_idx,
  output logic                  is_last
);

  logic [WORD_IDX_W-1:0] word_q, word_d;

  assign is_last  = (word_q == LAST_WORD);
  assign word_idx = word_q;

  always_comb begin
    // NOTE: default first so every path assigns word_d; a missing branch would infer a latch.
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (inc) begin
      word_d = is_last ? '0 : word_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/dcache_miss_controller.sv
// Data-cache miss controller for the dual-issue MEM stage.
// Detects a miss in either slot (slot 0 first), writes back a dirty victim
// word by word, refills the missing line word by word, writes the tag and
// releases the stall. One main-memory word is outstanding at a time.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   memread*/memwrite*/addr*     slot accesses in MEM
//   cache_hit*/valid_dirty*      per-slot lookup result and victim status
//   victim_addr*                 line-aligned victim address per slot
//   mm_req/mm_we/mm_addr         main-memory request (held until mm_ack)
//   mm_ack/mm_rdata              main-memory completion and read data
//   stall_latch_mem              stall request to the hazard logic
//   wb_word_idx                  victim word the cache drives during eviction
//   refill_we/_word_idx/_data    one refill word write into the data array
//   refill_tag_we                tag write, valid set, dirty cleared
//   refill_slot                  slot being serviced
//   miss_count                   saturating count of serviced misses
module dcache_miss_controller
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  memread0_mem,
  input  logic                  memwrite0_mem,
  input  logic                  memread1_mem,
  input  logic                  memwrite1_mem,
  input  logic [ADDR_W-1:0]     addr0_mem,
  input  logic [ADDR_W-1:0]     addr1_mem,
  input  logic                  cache_hit0_mem,
  input  logic                  cache_hit1_mem,
  input  logic                  valid_dirty0_mem,
  input  logic                  valid_dirty1_mem,
  input  logic [ADDR_W-1:0]     victim_addr0_mem,
  input  logic [ADDR_W-1:0]     victim_addr1_mem,
  input  logic                  mm_ack,
  input  logic [31:0]           mm_rdata,
  output logic                  stall_latch_mem,
  output logic                  mm_req,
  output logic                  mm_we,
  output logic [ADDR_W-1:0]     mm_addr,
  output logic [WORD_IDX_W-1:0] wb_word_idx,
  output logic                  refill_we,
  output logic [WORD_IDX_W-1:0] refill_word_idx,
  output logic [31:0]           refill_data,
  output logic                  refill_tag_we,
  output logic                  refill_slot,
  output logic [31:0]           miss_count
);

  state_e                state_q, state_d;
  logic                  slot_q, slot_d;
  logic [ADDR_W-1:0]     line_base_q, line_base_d;
  logic [ADDR_W-1:0]     victim_q, victim_d;
  logic                  refill_pend_q, refill_pend_d;
  logic [WORD_IDX_W-1:0] refill_idx_q, refill_idx_d;
  logic [31:0]           refill_data_q, refill_data_d;
  logic [31:0]           miss_count_q, miss_count_d;

  logic                  miss0, miss1;
  logic                  mm_fire;
  logic                  fill_last_wr;
  logic                  word_clr;
  logic                  word_last;
  logic [WORD_IDX_W-1:0] word_idx;

  assign miss0 = (memread0_mem | memwrite0_mem) & ~cache_hit0_mem;
  assign miss1 = (memread1_mem | memwrite1_mem) & ~cache_hit1_mem;

  // Acks without an outstanding request are ignored.
  assign mm_fire = mm_req & mm_ack;

  // Cycle in which the final refill word is written; no further request.
  assign fill_last_wr = refill_pend_q & (refill_idx_q == LAST_WORD);

  assign word_clr = (state_q == IDLE);

  // Gated by reset_n so the stall also drops while reset is held.
  assign stall_latch_mem = reset_n & ((state_q != IDLE) | miss0 | miss1);

  line_word_counter u_word_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (mm_fire),
    .clr      (word_clr),
    .word_idx (word_idx),
    .is_last  (word_last)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (miss0) begin
          state_d = valid_dirty0_mem ? WB : FILL;
        end else if (miss1) begin
          state_d = valid_dirty1_mem ? WB : FILL;
        end
      end
      WB:      if (mm_fire && word_last) state_d = FILL;
      FILL:    if (fill_last_wr) state_d = TAG;
      TAG:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    mm_req        = 1'b0;
    mm_we         = 1'b0;
    mm_addr       = '0;
    wb_word_idx   = '0;
    refill_tag_we = 1'b0;
    unique case (state_q)
      WB: begin
        mm_req      = 1'b1;
        mm_we       = 1'b1;
        mm_addr     = word_addr(victim_q, word_idx);
        wb_word_idx = word_idx;
      end
      FILL: begin
        mm_req  = ~fill_last_wr;
        mm_addr = word_addr(line_base_q, word_idx);
      end
      TAG:     refill_tag_we = 1'b1;
      default: ;
    endcase
  end

  // Transaction capture, refill staging and miss counting.
  always_comb begin
    slot_d        = slot_q;
    line_base_d   = line_base_q;
    victim_d      = victim_q;
    refill_pend_d = (state_q == FILL) & mm_fire;
    refill_idx_d  = refill_idx_q;
    refill_data_d = refill_data_q;
    miss_count_d  = miss_count_q;

    // All transaction state is latched here; later slot input changes are ignored.
    if (state_q == IDLE) begin
      if (miss0) begin
        slot_d      = 1'b0;
        line_base_d = line_base(addr0_mem);
        victim_d    = victim_addr0_mem;
      end else if (miss1) begin
        slot_d      = 1'b1;
        line_base_d = line_base(addr1_mem);
        victim_d    = victim_addr1_mem;
      end
    end

    if (refill_pend_d) begin
      refill_idx_d  = word_idx;
      refill_data_d = mm_rdata;
    end

    if (state_q == TAG && miss_count_q != '1) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q        <= 1'b0;
      line_base_q   <= '0;
      victim_q      <= '0;
      refill_pend_q <= 1'b0;
      refill_idx_q  <= '0;
      refill_data_q <= '0;
      miss_count_q  <= '0;
    end else begin
      slot_q        <= slot_d;
      line_base_q   <= line_base_d;
      victim_q      <= victim_d;
      refill_pend_q <= refill_pend_d;
      refill_idx_q  <= refill_idx_d;
      refill_data_q <= refill_data_d;
      miss_count_q  <= miss_count_d;
    end
  end

  assign refill_we       = refill_pend_q;
  assign refill_word_idx = refill_idx_q;
  assign refill_data     = refill_data_q;
  assign refill_slot     = slot_q;
  assign miss_count      = miss_count_q;

endmodule
